// File: rtl/serial_bus_if.sv
// Handshake and bus signals between serial_bus_port and the core/Arduino side.
// master: the port itself; slave: the core plus Arduino environment.
interface serial_bus_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BUS_W  = 8,
    parameter int unsigned NUM_CH = 3
) ();
    logic [NUM_CH-1:0]        tx_req;
    logic [NUM_CH*DATA_W-1:0] tx_data;
    logic [NUM_CH-1:0]        tx_grant;
    logic [NUM_CH-1:0]        tx_done;
    logic                     ard_receive_ready;
    logic [BUS_W-1:0]         out_bus;
    logic                     out_valid;
    logic                     ard_data_ready;
    logic [BUS_W-1:0]         in_bus;
    logic                     rx_clear;
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_valid;
    logic                     error;

    modport master (
        input  tx_req, tx_data, ard_receive_ready, ard_data_ready, in_bus, rx_clear,
        output tx_grant, tx_done, out_bus, out_valid, rx_data, rx_valid, error
    );

    modport slave (
        output tx_req, tx_data, ard_receive_ready, ard_data_ready, in_bus, rx_clear,
        input  tx_grant, tx_done, out_bus, out_valid, rx_data, rx_valid, error
    );
endinterface

// File: rtl/serial_bus_port.sv
// Arbitrated, MSB-beat-first word serialiser plus independent receive assembler.
// Define BUS_RR_ARB_EN for round-robin arbitration; default is fixed lowest-index priority.
module serial_bus_port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BUS_W  = 8,
    parameter int unsigned NUM_CH = 3
) (
    input logic          clk,
    input logic          rst,
    serial_bus_if.master bus
);
    localparam int unsigned BEATS = DATA_W / BUS_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;

    tx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [NUM_CH-1:0]  tx_grant_q, tx_grant_d;
    logic [NUM_CH-1:0]  tx_done_q, tx_done_d;
    logic               out_valid_q, out_valid_d;
    logic               error_q, error_d;
    logic [DATA_W-1:0]  rxsh_q, rxsh_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    logic [IDX_W-1:0]   win_idx_c;
    logic [NUM_CH-1:0]  win_onehot_c;
    logic [DATA_W-1:0]  win_word_c;
    logic               any_req_c;
    logic               last_beat_c;
    logic               abort_c;

`ifdef BUS_RR_ARB_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

    assign any_req_c   = |bus.tx_req;
    assign last_beat_c = (tx_cnt_q == CNT_W'(BEATS - 1));
    assign abort_c     = ~|(bus.tx_req & tx_grant_q);

    // Arbiter: pick the winning channel index
    always_comb begin
        win_idx_c = '0;
`ifdef BUS_RR_ARB_EN
        begin
            logic found;
            int   idx;
            found = 1'b0;
            idx   = 0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
                if (!found && bus.tx_req[idx]) begin
                    found     = 1'b1;
                    win_idx_c = IDX_W'(idx);
                end
            end
        end
`else
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (bus.tx_req[i]) win_idx_c = IDX_W'(i);
        end
`endif
    end

    // Winner one-hot and word
    always_comb begin
        win_onehot_c = '0;
        win_word_c   = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (win_idx_c == IDX_W'(i)) begin
                win_onehot_c[i] = any_req_c;
                win_word_c      = bus.tx_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_req_c) state_d = SEND;
            SEND: if (abort_c || (bus.ard_receive_ready && last_beat_c)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // TX outputs and datapath; abort takes precedence over a coincident final beat
    always_comb begin
        tx_grant_d  = tx_grant_q;
        tx_done_d   = '0;
        error_d     = 1'b0;
        out_valid_d = out_valid_q;
        shreg_d     = shreg_q;
        tx_cnt_d    = tx_cnt_q;
`ifdef BUS_RR_ARB_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    tx_grant_d  = win_onehot_c;
                    shreg_d     = win_word_c;
                    tx_cnt_d    = '0;
                    out_valid_d = 1'b1;
`ifdef BUS_RR_ARB_EN
                    ptr_d = (win_idx_c == IDX_W'(NUM_CH - 1)) ? '0 : win_idx_c + IDX_W'(1);
`endif
                end
            end
            SEND: begin
                if (bus.ard_receive_ready) begin
                    shreg_d  = shreg_q << BUS_W;
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
                if (abort_c) begin
                    tx_grant_d  = '0;
                    out_valid_d = 1'b0;
                    error_d     = 1'b1;
                end else if (bus.ard_receive_ready && last_beat_c) begin
                    tx_grant_d  = '0;
                    out_valid_d = 1'b0;
                    tx_done_d   = tx_grant_q;
                end
            end
            default: ;
        endcase
    end

    // RX assembler; clear wins over a coincident beat
    always_comb begin
        rxsh_d     = rxsh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (bus.rx_clear) begin
            rx_cnt_d = '0;
        end else if (bus.ard_data_ready) begin
            rxsh_d = DATA_W'({rxsh_q, bus.in_bus});
            if (rx_cnt_q == CNT_W'(BEATS - 1)) begin
                rx_cnt_d   = '0;
                rx_data_d  = rxsh_d;
                rx_valid_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            tx_cnt_q    <= '0;
            tx_grant_q  <= '0;
            tx_done_q   <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            rxsh_q      <= '0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_grant_q  <= tx_grant_d;
            tx_done_q   <= tx_done_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
            rxsh_q      <= rxsh_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

`ifdef BUS_RR_ARB_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign bus.tx_grant  = tx_grant_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bus   = out_valid_q ? shreg_q[DATA_W-1 -: BUS_W] : '0;
    assign bus.error     = error_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
endmodule
